// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared constants, loader state encoding and bit-reverse helper for the NTT front end
//
// Contents:
//   NTT_K, NTT_N, NTT_N_BITS, NTT_Q : default coefficient width, polynomial length,
//                                     address width and modulus
//   loader_state_t                  : state encoding of the polynomial loader FSM
//   bitrev()                        : reverse the low w bits of a value

package ntt_pkg;

    localparam int unsigned NTT_K      = 32;
    localparam int unsigned NTT_N      = 256;
    localparam int unsigned NTT_N_BITS = 8;
    localparam int unsigned NTT_Q      = 8380417;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_FLUSH     = 3'd2,
        ST_START     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DONE      = 3'd5
    } loader_state_t;

    // Reverse the whole 32-bit word, then shift the reversed low w bits back
    // down so only the index field of width w is mirrored.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned w);
        logic [31:0] r;
        r = {<<{v}};
        return r >> (32 - w);
    endfunction

endpackage

// File: rtl/mod_cond_sub.sv
// rtl/mod_cond_sub.sv - single conditional-subtract reduction of x in [0, 2Q) to [0, Q)
//
// Parameters: K (data width), Q (modulus, 2*Q < 2**K)
// Ports:
//   i_x   input  K  value to reduce
//   o_y   output K  x < Q ? x : x - Q
//   o_err output 1  x >= 2Q, so o_y is not a valid residue

module mod_cond_sub #(
    parameter int unsigned K = 32,
    parameter int unsigned Q = 8380417
) (
    input  logic [K-1:0] i_x,
    output logic [K-1:0] o_y,
    output logic         o_err
);

    localparam logic [K:0] Q_EXT  = (K+1)'(Q);
    localparam logic [K:0] Q2_EXT = Q_EXT << 1;

    logic [K:0] w_x;
    logic [K:0] w_diff;

    assign w_x    = {1'b0, i_x};
    // Subtracting in K+1 bits: the top bit is the borrow, set exactly when x < Q.
    assign w_diff = w_x - Q_EXT;
    assign o_y    = w_diff[K] ? i_x : w_diff[K-1:0];
    assign o_err  = (w_x >= Q2_EXT);

endmodule

// File: rtl/ntt_poly_loader.sv
// rtl/ntt_poly_loader.sv - streams N coefficients mod Q into the poly BRAM, then runs the NTT controller
//
// Build option: NTT_LOADER_BITREV_EN - write coefficient k to bit-reversed address
//               (default: natural order, address k).
//
// Parameters: K (data width), N (coefficients), N_bits (log2 N), Q (modulus)
// Ports:
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_load_req, i_load_is_intt      start a load+transform, direction sampled with it
//   i_in_valid/o_in_ready,
//   i_in_data, i_in_last            coefficient stream
//   o_bram_we/o_bram_addr/o_bram_din BRAM port A write, one cycle after accept
//   o_ntt_start/o_ntt_is_intt,
//   i_ntt_done                      NTT controller handshake
//   o_busy, o_load_done             status; load_done is a one-cycle pulse
//   o_range_err, o_frame_err        sticky errors, cleared by an accepted load_req

module ntt_poly_loader
    import ntt_pkg::*;
#(
    parameter int unsigned K      = NTT_K,
    parameter int unsigned N      = NTT_N,
    parameter int unsigned N_bits = NTT_N_BITS,
    parameter int unsigned Q      = NTT_Q
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load_req,
    input  logic              i_load_is_intt,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [K-1:0]      i_in_data,
    input  logic              i_in_last,
    output logic              o_bram_we,
    output logic [N_bits-1:0] o_bram_addr,
    output logic [K-1:0]      o_bram_din,
    output logic              o_ntt_start,
    output logic              o_ntt_is_intt,
    input  logic              i_ntt_done,
    output logic              o_busy,
    output logic              o_load_done,
    output logic              o_range_err,
    output logic              o_frame_err
);

    localparam logic [N_bits-1:0] LAST_IDX = N_bits'(N - 1);

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;

    logic [N_bits-1:0] r_cnt;
    logic              r_is_intt;
    logic              r_we;
    logic [N_bits-1:0] r_addr;
    logic [K-1:0]      r_din;
    logic              r_range_err;
    logic              r_frame_err;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_last_beat;
    logic              w_start_state;
    logic [N_bits-1:0] w_addr;
    logic [K-1:0]      w_red;
    logic              w_red_err;

    mod_cond_sub #(
        .K (K),
        .Q (Q)
    ) u_red (
        .i_x   (i_in_data),
        .o_y   (w_red),
        .o_err (w_red_err)
    );

`ifdef NTT_LOADER_BITREV_EN
    assign w_addr = N_bits'(bitrev(32'(r_cnt), N_bits));
`else
    assign w_addr = r_cnt;
`endif

    assign w_accept    = w_in_ready && i_in_valid;
    assign w_last_beat = (r_cnt == LAST_IDX);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_in_ready    = 1'b0;
        w_start_state = 1'b0;
        o_busy        = 1'b1;
        o_load_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_load_req) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_in_ready = 1'b1;
                if (w_accept && w_last_beat) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            // The final beat's registered write is on the BRAM port this cycle;
            // the controller is only started once it has landed.
            ST_FLUSH: begin
                w_state_nxt = ST_START;
            end
            ST_START: begin
                w_start_state = 1'b1;
                w_state_nxt   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                w_start_state = 1'b1;
                if (i_ntt_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                o_load_done = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: one-cycle registered BRAM write, beat counter, sticky errors
    // and the latched transform direction.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt       <= '0;
            r_is_intt   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_din       <= '0;
            r_range_err <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_addr <= w_addr;
                r_din  <= w_red;
                r_cnt  <= r_cnt + 1'b1;
                if (w_red_err) begin
                    r_range_err <= 1'b1;
                end
                // Covers both an early in_last and a missing one on beat N-1.
                if (i_in_last != w_last_beat) begin
                    r_frame_err <= 1'b1;
                end
            end
            if ((r_state == ST_IDLE) && i_load_req) begin
                r_is_intt   <= i_load_is_intt;
                r_cnt       <= '0;
                r_range_err <= 1'b0;
                r_frame_err <= 1'b0;
            end
        end
    end

    assign o_in_ready    = w_in_ready;
    assign o_bram_we     = r_we;
    assign o_bram_addr   = r_addr;
    assign o_bram_din    = r_din;
    // Gated by reset directly so an abandoned transform releases the
    // controller in the very cycle the reset is seen.
    assign o_ntt_start   = w_start_state && !i_reset;
    assign o_ntt_is_intt = r_is_intt;
    assign o_range_err   = r_range_err;
    assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_ntt_poly_loader.sv
// tb/tb_ntt_poly_loader.sv - self-checking bench for ntt_poly_loader

module tb_ntt_poly_loader;

    localparam int          N  = 256;
    localparam logic [31:0] QV = 32'd8380417;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_load_req = 1'b0;
    logic        i_load_is_intt = 1'b0;
    logic        i_in_valid = 1'b0;
    logic [31:0] i_in_data = '0;
    logic        i_in_last = 1'b0;
    logic        i_ntt_done = 1'b0;
    logic        o_in_ready, o_bram_we, o_ntt_start, o_ntt_is_intt;
    logic        o_busy, o_load_done, o_range_err, o_frame_err;
    logic [7:0]  o_bram_addr;
    logic [31:0] o_bram_din;

    ntt_poly_loader dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_load_req     (i_load_req),
        .i_load_is_intt (i_load_is_intt),
        .i_in_valid     (i_in_valid),
        .o_in_ready     (o_in_ready),
        .i_in_data      (i_in_data),
        .i_in_last      (i_in_last),
        .o_bram_we      (o_bram_we),
        .o_bram_addr    (o_bram_addr),
        .o_bram_din     (o_bram_din),
        .o_ntt_start    (o_ntt_start),
        .o_ntt_is_intt  (o_ntt_is_intt),
        .i_ntt_done     (i_ntt_done),
        .o_busy         (o_busy),
        .o_load_done    (o_load_done),
        .o_range_err    (o_range_err),
        .o_frame_err    (o_frame_err)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] vec [N];
    logic [31:0] mem [N];
    logic [7:0]  addr_log [4];
    int          wr_count = 0;
    logic [7:0]  first_addr = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h required %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] red_ref(input logic [31:0] x);
        if (x >= QV) return x - QV;
        return x;
    endfunction

`ifdef NTT_LOADER_BITREV_EN
    function automatic logic [7:0] map_addr(input int b);
        logic [7:0] v;
        logic [7:0] r;
        v = 8'(b);
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction
`else
    function automatic logic [7:0] map_addr(input int b);
        return 8'(b);
    endfunction
`endif

    // Timeline model: expected outputs come from the cycle numbers of the
    // load request, the final accepted beat and the sampled done.
    int          t_req = -1, t_last = -1, t_done = -1, beats = 0;
    bit          p_we = 0, m_rerr = 0, m_ferr = 0, m_intt = 0;
    logic [7:0]  p_addr = '0;
    logic [31:0] p_din = '0;

    always @(negedge clk) begin
        bit e_busy, e_ready, e_start, e_ldone;
        int c;
        c       = cyc;
        e_busy  = (t_req >= 0) && (c > t_req) && !((t_done >= 0) && (c > t_done + 1));
        e_ready = e_busy && (t_last < 0);
        e_start = !i_reset && (t_last >= 0) && (c >= t_last + 2) && ((t_done < 0) || (c <= t_done));
        e_ldone = (t_done >= 0) && (c == t_done + 1);
        chk("busy", o_busy, e_busy);
        chk("in_ready", o_in_ready, e_ready);
        chk("ntt_start", o_ntt_start, e_start);
        chk("load_done", o_load_done, e_ldone);
        chk("bram_we", o_bram_we, p_we);
        if (p_we) begin
            chk("bram_addr", o_bram_addr, p_addr);
            chk("bram_din", o_bram_din, p_din);
        end
        chk("range_err", o_range_err, m_rerr);
        chk("frame_err", o_frame_err, m_ferr);
        chk("ntt_is_intt", o_ntt_is_intt, m_intt);

        if (o_bram_we === 1'b1) begin
            if (wr_count < 4) addr_log[wr_count] = o_bram_addr;
            if (wr_count == 0) first_addr = o_bram_addr;
            wr_count++;
            mem[o_bram_addr] = o_bram_din;
        end

        p_we = 0;
        if (i_reset) begin
            t_req = -1; t_last = -1; t_done = -1; beats = 0;
            m_rerr = 0; m_ferr = 0; m_intt = 0;
        end else begin
            if (!e_busy && i_load_req) begin
                t_req = c; t_last = -1; t_done = -1; beats = 0;
                m_rerr = 0; m_ferr = 0; m_intt = i_load_is_intt;
            end else if (e_ready && i_in_valid) begin
                p_we   = 1;
                p_addr = map_addr(beats);
                p_din  = red_ref(i_in_data);
                if (i_in_data >= 2 * QV) m_rerr = 1;
                if (i_in_last != (beats == N - 1)) m_ferr = 1;
                if (beats == N - 1) t_last = c;
                beats++;
            end
            if ((t_last >= 0) && (t_done < 0) && (c >= t_last + 3) && i_ntt_done) t_done = c;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_start"}, o_ntt_start, 0);
        chk({tag, "_we"}, o_bram_we, 0);
        chk({tag, "_addr"}, o_bram_addr, 0);
        chk({tag, "_din"}, o_bram_din, 0);
        chk({tag, "_ready"}, o_in_ready, 0);
        chk({tag, "_ldone"}, o_load_done, 0);
        chk({tag, "_rerr"}, o_range_err, 0);
        chk({tag, "_ferr"}, o_frame_err, 0);
        chk({tag, "_intt"}, o_ntt_is_intt, 0);
    endtask

    task automatic do_load(input bit intt, input int last_at, input bit stall,
                           input int reset_at, input int done_delay, input bit poke_req);
        int b, k, acc_cyc, rise, guard;
        bit acc, held;
        b = 0; k = 0; acc_cyc = -1; rise = -1; guard = 0; held = 1;
        wr_count = 0;
        @(posedge clk); #1;
        i_load_req = 1; i_load_is_intt = intt;
        @(posedge clk); #1;
        i_load_req = 0; i_load_is_intt = 0;
        chk("req_clears_rerr", o_range_err, 0);
        chk("req_clears_ferr", o_frame_err, 0);
        chk("busy_after_req", o_busy, 1);
        while ((b < N) && (guard < 4 * N)) begin
            guard++;
            if (b == reset_at) begin
                i_in_valid = 0; i_in_last = 0; i_reset = 1;
                @(posedge clk); #1;
                i_reset = 0;
                chk_all_zero("after_reset");
                return;
            end
            i_in_valid = !stall || (k % 4 == 0) || (k % 4 == 3);
            k++;
            i_in_data = vec[b];
            i_in_last = (b == last_at);
            acc = i_in_valid && o_in_ready;
            if (acc && (b == N - 1)) acc_cyc = cyc;
            @(posedge clk); #1;
            if (acc) b++;
        end
        i_in_valid = 0; i_in_last = 0;
        chk("beats_accepted", b, N);
        chk("ready_low_after_last", o_in_ready, 0);
        for (int i = 0; (i < 8) && (rise < 0); i++) begin
            if (o_ntt_start) rise = cyc;
            else begin @(posedge clk); #1; end
        end
        chk("start_latency", rise - acc_cyc, 2);
        for (int i = 0; i < done_delay; i++) begin
            @(posedge clk); #1;
            if (!o_ntt_start) held = 0;
            i_load_req = poke_req && (i == done_delay / 2);
            i_load_is_intt = !intt;
        end
        i_load_req = 0; i_load_is_intt = 0;
        chk("start_held", held, 1);
        i_ntt_done = 1;
        @(posedge clk); #1;
        i_ntt_done = 0;
        chk("start_drop_after_done", o_ntt_start, 0);
        chk("load_done_pulse", o_load_done, 1);
        chk("intt_latched", o_ntt_is_intt, intt);
        @(posedge clk); #1;
        chk("load_done_single", o_load_done, 0);
        chk("busy_drops", o_busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        i_reset = 0;
        chk_all_zero("reset");

        // Natural-order load, long controller wait, ignored load_req in WAIT_DONE
        for (int k = 0; k < N; k++) vec[k] = k;
        do_load(0, N - 1, 0, -1, 1000, 1);
        chk("A_writes", wr_count, 256);
        chk("A_mem0", mem[map_addr(0)], 0);
        chk("A_mem17", mem[map_addr(17)], 17);
        chk("A_mem255", mem[map_addr(255)], 255);
        chk("A_rerr", o_range_err, 0);
        chk("A_ferr", o_frame_err, 0);
`ifdef NTT_LOADER_BITREV_EN
        chk("A_addr0", addr_log[0], 0);
        chk("A_addr1", addr_log[1], 128);
        chk("A_addr2", addr_log[2], 64);
        chk("A_addr3", addr_log[3], 192);
`else
        chk("A_addr0", addr_log[0], 0);
        chk("A_addr1", addr_log[1], 1);
        chk("A_addr2", addr_log[2], 2);
        chk("A_addr3", addr_log[3], 3);
`endif

        // Reduction boundaries
        vec[0] = QV - 1; vec[1] = QV; vec[2] = QV + 5; vec[3] = 2 * QV - 1;
        do_load(1, N - 1, 0, -1, 1, 0);
        chk("B_red_qm1", mem[map_addr(0)], 32'd8380416);
        chk("B_red_q", mem[map_addr(1)], 32'd0);
        chk("B_red_q5", mem[map_addr(2)], 32'd5);
        chk("B_red_2qm1", mem[map_addr(3)], 32'd8380416);
        chk("B_rerr", o_range_err, 0);

        // Out-of-range beat: sticky until the next request
        vec[0] = 2 * QV;
        do_load(0, N - 1, 0, -1, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("C_rerr_sticky", o_range_err, 1);
        vec[0] = 0;

        // Stalled input
        do_load(0, N - 1, 1, -1, 1, 0);
        chk("D_writes", wr_count, 256);
        chk("D_ready_idle", o_in_ready, 0);
        chk("D_mem200", mem[map_addr(200)], 200);

        // Early in_last
        do_load(0, 100, 0, -1, 1, 0);
        chk("E_ferr", o_frame_err, 1);
        chk("E_writes", wr_count, 256);

        // Reset mid-load, then a clean load
        do_load(0, N - 1, 0, 50, 1, 0);
        do_load(0, N - 1, 0, -1, 1, 0);
        chk("F_first_addr", first_addr, 0);
        chk("F_writes", wr_count, 256);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_poly_loader.md
Name: ntt_poly_loader

Overview:
- Upstream feeder stage for the pipelined NTT controller.
- Accepts a valid/ready stream of N coefficients and reduces each one mod Q.
- Writes the coefficients into the polynomial dual-port BRAM on port A.
- Then issues start/is_intt to the NTT controller, holds start until the controller's done, and reports completion upstream.

Parameters:
- K, 32, coefficient/data width in bits
- N, 256, coefficients per polynomial
- N_bits, 8, log2(N); BRAM address width
- Q, 8380417, modulus; must satisfy 2*Q < 2**K

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- load_req  input  1  one-cycle pulse requesting a load+transform
- load_is_intt  input  1  transform direction; sampled with load_req
- in_valid  input  1  coefficient beat valid
- in_ready  output  1  loader can accept a beat
- in_data  input  K  coefficient value, expected in [0, 2Q)
- in_last  input  1  marks the final beat of the polynomial
- bram_we  output  1  write enable to poly BRAM port A
- bram_addr  output  N_bits  write address
- bram_din  output  K  reduced coefficient
- ntt_start  output  1  start to the NTT controller
- ntt_is_intt  output  1  direction to the NTT controller
- ntt_done  input  1  done from the NTT controller
- busy  output  1  high in any state except IDLE
- load_done  output  1  one-cycle completion pulse
- range_err  output  1  sticky; some beat had in_data >= 2Q
- frame_err  output  1  sticky; in_last did not coincide with beat N-1

Behaviour:
- Reset (synchronous, active-high):
  - Every output goes to 0 and the FSM goes to IDLE.
  - Beat counter and latched direction clear.
  - A reset mid-load or mid-transform abandons the operation and drops ntt_start the same cycle the reset is seen.
- FSM states: IDLE, LOAD, FLUSH, START, WAIT_DONE, DONE.
- IDLE:
  - On load_req: latch load_is_intt into ntt_is_intt, clear cnt, range_err and frame_err, go to LOAD.
  - load_req in any other state is ignored.
- LOAD:
  - in_ready = 1. A beat is accepted when in_valid && in_ready.
  - Accepted beat at cnt: the next cycle drives bram_we=1, bram_addr=cnt, bram_din=red(in_data). Write latency is 1 cycle.
  - cnt increments per accepted beat.
  - When beat N-1 is accepted, go to FLUSH; in_ready is 0 from the next cycle.
- Early in_last: if in_last is accepted with cnt != N-1, set frame_err and keep loading until N beats.
- Missing in_last: if in_last is 0 on beat N-1, set frame_err.
- FLUSH: one cycle; the last registered write retires. Go to START.
- START: assert ntt_start; go to WAIT_DONE.
- WAIT_DONE:
  - ntt_start stays high until ntt_done is sampled high, then deasserts the following cycle.
  - Go to DONE.
- DONE: load_done = 1 for exactly one cycle; go to IDLE.
- Reduction, red(x):
  - x < Q → x; otherwise x - Q. A single conditional subtract, computed in K+1 bits.
  - x >= 2Q: set range_err and write red(x) anyway (result is out of range, undefined but deterministic).
- Stalls: in_valid may deassert between beats. Nothing is written and cnt holds.
- busy = (state != IDLE).
- ntt_is_intt holds its latched value until the next accepted load_req.

Optional Feature:
- Macro NTT_LOADER_BITREV_EN.
- Defined: bram_addr = bit-reverse of cnt over N_bits (cnt=1 → addr 128 for N_bits=8). Used when the NTT schedule expects bit-reversed input.
- Undefined: bram_addr = cnt, natural order.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package ntt_pkg holds:
  - default K, N, N_bits, Q constants
  - loader_state_t enum
  - bitrev function
- One sub-module is natural: mod_cond_sub.
  - Combinational x → {red(x), err}, parameterised on K and Q.
  - Reused later by the pointwise-multiply and output-unload stages.

Test Plan:
- Natural-order load:
  - Stimulus: load_req with is_intt=0; stream 0..255 with in_valid held high, in_last on beat 255.
  - Required: addr k holds k; bram_we asserted 256 cycles total; ntt_start rises 2 cycles after the last accept; no errors.
- Reduction:
  - Stimulus: beats Q-1, Q, Q+5, 2Q-1.
  - Required: written values 8380416, 0, 5, 8380416; range_err=0.
  - Follow-up: a beat of 2Q sets range_err=1, which stays 1 until the next load_req.
- Stalled input:
  - Stimulus: in_valid toggles 1,0,0,1 pattern across the full 256 beats.
  - Required: exactly 256 writes, addresses contiguous, in_ready low after beat 255.
- Handshake with controller:
  - Stimulus: ntt_done held low 1000 cycles after start, then pulsed.
  - Required: ntt_start high throughout, low the cycle after done; load_done pulses once; busy drops.
  - Also: a load_req issued during WAIT_DONE is ignored.
- Framing and reset:
  - Stimulus: in_last on beat 100.
  - Required: frame_err=1 and the load still completes at 256 beats.
  - Stimulus: reset asserted at beat 50 of a second load.
  - Required: all outputs 0 next cycle; a following load starts writing at addr 0.
- Bit-reverse build (NTT_LOADER_BITREV_EN defined):
  - Stimulus: beats 0,1,2,3.
  - Required: addrs 0, 128, 64, 192.
